// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Holds state/action encodings and the hard-wired zero register index.
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN,
      MEM_WAIT
   } state_t;

   typedef enum logic [1:0] {
      ACT_RUN,
      ACT_STALL,
      ACT_FLUSH,
      ACT_FREEZE
   } action_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear wins over a coincident increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && !(&count))
         count <= count + W'(1);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush,
// data-memory freeze, wait watchdog and performance counters.
module hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             mem_branch_taken,
   input  logic             mem_access,
   input  logic             dmem_ready,
   input  logic             clr_stats,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             pipe_freeze,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] freeze_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] W_MAX  = WW'(TIMEOUT);
   localparam logic [WW-1:0] W_TRIP = WW'(TIMEOUT - 2);

   state_t        state;
   state_t        state_nx;
   action_t       act;
   logic [WW-1:0] wcnt;
   logic          lu;
   logic          mw;

   always_comb begin
      lu = id_valid && ex_mem_read && (ex_rt != REG_ZERO)
           && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      mw = mem_access && !dmem_ready;
   end

   // Freeze outranks flush, which outranks the load-use stall.
   always_comb begin
      act = ACT_RUN;
      if (mw)
         act = ACT_FREEZE;
      else if (mem_branch_taken)
         act = ACT_FLUSH;
      else if (lu)
         act = ACT_STALL;
      if (reset)
         act = ACT_RUN;
   end

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      pipe_freeze  = 1'b0;
      unique case (act)
         ACT_FREEZE: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
         end
         ACT_FLUSH: begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
         end
         ACT_STALL: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         RUN:      if (mw) state_nx = MEM_WAIT;
         MEM_WAIT: if (dmem_ready) state_nx = RUN;
         default:  state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= RUN;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wcnt <= '0;
      else if (state == RUN)
         wcnt <= '0;
      else if (wcnt != W_MAX)
         wcnt <= wcnt + WW'(1);
   end

   // Sticky: trips on the edge where wcnt reaches TIMEOUT-1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         mem_timeout <= 1'b0;
      else if (state == MEM_WAIT && mw && wcnt >= W_TRIP)
         mem_timeout <= 1'b1;
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (act == ACT_STALL),
      .clr   (clr_stats),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_freeze_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (act == ACT_FREEZE),
      .clr   (clr_stats),
      .count (freeze_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (act == ACT_FLUSH),
      .clr   (clr_stats),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a behavioural model.
// Small TIMEOUT and CNT_W so watchdog and saturation are reachable.
module tb_hazard_ctrl;

   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 4;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             id_valid;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             ex_mem_read;
   logic [4:0]       ex_rt;
   logic             mem_branch_taken;
   logic             mem_access;
   logic             dmem_ready;
   logic             clr_stats;
   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             ex_mem_flush;
   logic             pipe_freeze;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] freeze_cnt;
   logic [CNT_W-1:0] flush_cnt;

   int total = 0;
   int bad   = 0;

   // model state
   bit m_wait;
   int m_wlen;
   bit m_to;
   int m_stall;
   int m_freeze;
   int m_flush;

   hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .id_valid         (id_valid),
      .id_rs            (id_rs),
      .id_rt            (id_rt),
      .id_uses_rt       (id_uses_rt),
      .ex_mem_read      (ex_mem_read),
      .ex_rt            (ex_rt),
      .mem_branch_taken (mem_branch_taken),
      .mem_access       (mem_access),
      .dmem_ready       (dmem_ready),
      .clr_stats        (clr_stats),
      .pc_write         (pc_write),
      .if_id_write      (if_id_write),
      .if_id_flush      (if_id_flush),
      .id_ex_flush      (id_ex_flush),
      .ex_mem_flush     (ex_mem_flush),
      .pipe_freeze      (pipe_freeze),
      .mem_timeout      (mem_timeout),
      .stall_cnt        (stall_cnt),
      .freeze_cnt       (freeze_cnt),
      .flush_cnt        (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int x);
      return (x >= CMAX) ? CMAX : x + 1;
   endfunction

   task automatic model_clear();
      m_wait   = 0;
      m_wlen   = 0;
      m_to     = 0;
      m_stall  = 0;
      m_freeze = 0;
      m_flush  = 0;
   endtask

   task automatic idle_inputs();
      id_valid         = 0;
      id_rs            = 0;
      id_rt            = 0;
      id_uses_rt       = 0;
      ex_mem_read      = 0;
      ex_rt            = 0;
      mem_branch_taken = 0;
      mem_access       = 0;
      dmem_ready       = 1;
      clr_stats        = 0;
   endtask

   task automatic chk_regs(input string pfx);
      chk({pfx, "_tmo"},    int'(mem_timeout), int'(m_to));
      chk({pfx, "_stall"},  int'(stall_cnt),   m_stall);
      chk({pfx, "_freeze"}, int'(freeze_cnt),  m_freeze);
      chk({pfx, "_flush"},  int'(flush_cnt),   m_flush);
   endtask

   // Asserted mid-cycle, away from the clock edge.
   task automatic do_reset();
      @(negedge clk);
      #2;
      reset = 1;
      #1;
      model_clear();
      chk_regs("rst");
      id_valid         = 1;
      ex_mem_read      = 1;
      ex_rt            = 5'd3;
      id_rs            = 5'd3;
      mem_branch_taken = 1'($urandom_range(0, 1));
      mem_access       = 1;
      dmem_ready       = 0;
      #1;
      chk("rst_pcw",  int'(pc_write),     1);
      chk("rst_ifw",  int'(if_id_write),  1);
      chk("rst_iff",  int'(if_id_flush),  0);
      chk("rst_idf",  int'(id_ex_flush),  0);
      chk("rst_exf",  int'(ex_mem_flush), 0);
      chk("rst_frz",  int'(pipe_freeze),  0);
      idle_inputs();
      @(negedge clk);
      reset = 0;
   endtask

   task automatic cyc(input logic v, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt,
                      input logic emr, input logic [4:0] ert,
                      input logic br, input logic ma,
                      input logic rdy, input logic clr);
      bit lu_m, mw_m;
      int e_pc, e_ifw, e_iff, e_idf, e_exf, e_frz;
      @(negedge clk);
      id_valid         = v;
      id_rs            = rs;
      id_rt            = rt;
      id_uses_rt       = urt;
      ex_mem_read      = emr;
      ex_rt            = ert;
      mem_branch_taken = br;
      mem_access       = ma;
      dmem_ready       = rdy;
      clr_stats        = clr;
      #1;
      chk_regs("reg");
      lu_m = v && emr && (ert != 0) && (ert == rs || (urt && ert == rt));
      mw_m = ma && !rdy;
      e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_exf = 0; e_frz = 0;
      if (mw_m) begin
         e_pc = 0; e_ifw = 0; e_frz = 1;
      end else if (br) begin
         e_iff = 1; e_idf = 1; e_exf = 1;
      end else if (lu_m) begin
         e_pc = 0; e_ifw = 0; e_idf = 1;
      end
      chk("pcw", int'(pc_write),     e_pc);
      chk("ifw", int'(if_id_write),  e_ifw);
      chk("iff", int'(if_id_flush),  e_iff);
      chk("idf", int'(id_ex_flush),  e_idf);
      chk("exf", int'(ex_mem_flush), e_exf);
      chk("frz", int'(pipe_freeze),  e_frz);
      // model advance for the coming edge
      if (clr) begin
         m_stall = 0; m_freeze = 0; m_flush = 0;
      end else begin
         if (mw_m)           m_freeze = sat(m_freeze);
         else if (br)        m_flush  = sat(m_flush);
         else if (lu_m)      m_stall  = sat(m_stall);
      end
      if (m_wait && mw_m && (m_wlen + 1 >= TIMEOUT - 1))
         m_to = 1;
      if (!m_wait) begin
         m_wlen = 0;
         m_wait = mw_m;
      end else begin
         m_wlen = (m_wlen >= TIMEOUT) ? TIMEOUT : m_wlen + 1;
         m_wait = !rdy;
      end
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      model_clear();
      #3;
      chk_regs("por");
      @(negedge clk);
      reset = 0;

      // load-use on rs, then the $0 case
      cyc(1, 8, 0, 0, 1, 8, 0, 0, 1, 0);
      after_edge();
      chk("lu_stall1", int'(stall_cnt), 1);
      cyc(1, 0, 0, 1, 1, 0, 0, 0, 1, 0);
      chk("zero_pcw", int'(pc_write), 1);

      // rt dependency gated by id_uses_rt
      cyc(1, 1, 9, 1, 1, 9, 0, 0, 1, 0);
      chk("rt_stall", int'(id_ex_flush), 1);
      cyc(1, 1, 9, 0, 1, 9, 0, 0, 1, 0);
      chk("rt_run", int'(id_ex_flush), 0);

      // branch with coincident load-use
      do_reset();
      cyc(1, 8, 0, 0, 1, 8, 1, 0, 1, 0);
      after_edge();
      chk("br_flush1", int'(flush_cnt), 1);
      chk("br_stall0", int'(stall_cnt), 0);

      // memory wait, then wait with a pending branch
      do_reset();
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      after_edge();
      chk("mw_frz5", int'(freeze_cnt), 5);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
      chk("mw_brflush", int'(ex_mem_flush), 1);
      after_edge();
      chk("mw_flush1", int'(flush_cnt), 1);

      // watchdog
      do_reset();
      for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      after_edge();
      chk("wd_not_yet", int'(mem_timeout), 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      after_edge();
      chk("wd_set", int'(mem_timeout), 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      after_edge();
      chk("wd_sticky", int'(mem_timeout), 1);
      do_reset();
      chk("wd_clr", int'(mem_timeout), 0);

      // saturation and clear
      for (int i = 0; i < 20; i++) cyc(1, 4, 0, 0, 1, 4, 0, 0, 1, 0);
      after_edge();
      chk("sat_stall", int'(stall_cnt), 15);
      cyc(1, 4, 0, 0, 1, 4, 0, 0, 1, 1);
      after_edge();
      chk("clr_stall", int'(stall_cnt), 0);

      // async reset mid-wait
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      do_reset();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("post_rst_run", int'(pipe_freeze), 0);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         logic [4:0] rs, rt, ert;
         logic rdy;
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            ert = 5'($urandom_range(0, 3));
            rdy = (n % 200 > 150) ? ($urandom_range(0, 9) == 0)
                                  : ($urandom_range(0, 3) != 0);
            cyc(1'($urandom_range(0, 1)), rs, rt,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ert,
                ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                rdy, ($urandom_range(0, 49) == 0));
         end
      end
      after_edge();
      chk_regs("end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
